khani_unsort: RTL and testbench

KHANI_UNSORT -- requirements
Module: khani_unsort

---
 rtl/khani_pkg.sv | 20 ++
 rtl/khani_scatter_buf.sv | 70 +++++++
 rtl/khani_unsort.sv | 112 +++++++++++
 tb/tb_khani_unsort.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/khani_pkg.sv
// Shared definitions for the khani sort/unsort blocks: default frame
// geometry, the index-width helper and the load/drain state encoding.
package khani_pkg;

    localparam int KHANI_N     = 6;
    localparam int KHANI_WIDTH = 8;

    // Index width is clog2(n), but never narrower than one bit.
    function automatic int khani_idxw(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int KHANI_IDXW = khani_idxw(KHANI_N);

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } khani_state_t;

endpackage

// File: rtl/khani_scatter_buf.sv
// N-entry scatter buffer with one occupied bit per slot. One write port,
// one combinational read port (unoccupied slots read as zero), an
// occupancy probe at the write address, and a synchronous clear of the
// occupied bits.
module khani_scatter_buf
    import khani_pkg::*;
#(
    parameter  int N     = KHANI_N,
    parameter  int WIDTH = KHANI_WIDTH,
    localparam int IDXW  = khani_idxw(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_we,
    input  logic [IDXW-1:0]  i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [IDXW-1:0]  i_raddr,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_wocc
);

    logic [WIDTH-1:0] r_mem [N];
    logic [N-1:0]     r_occ;

    // Slot storage: write the addressed slot; addresses >= N match nothing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_we && (i_waddr == IDXW'(i))) begin
                    r_mem[i] <= i_wdata;
                end
            end
        end
    end

    // Occupied bits: clear wins over a write so a new frame starts empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (i_clr) begin
            r_occ <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (i_we && (i_waddr == IDXW'(i))) begin
                    r_occ[i] <= 1'b1;
                end
            end
        end
    end

    // Combinational read of the drain slot and occupancy of the write slot.
    always_comb begin
        o_rdata = '0;
        o_wocc  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if ((i_raddr == IDXW'(i)) && r_occ[i]) begin
                o_rdata = r_mem[i];
            end
            if (i_waddr == IDXW'(i)) begin
                o_wocc = r_occ[i];
            end
        end
    end

endmodule

// File: rtl/khani_unsort.sv
// Restores original element order of a sorted frame: each element is
// scattered to the slot named by its pre-sort index, then slots 0..N-1
// are streamed out. A sticky err flags bad/duplicate indices and frames
// whose length disagrees with N; it clears when the frame drains.
module khani_unsort
    import khani_pkg::*;
#(
    parameter  int N     = KHANI_N,
    parameter  int WIDTH = KHANI_WIDTH,
    localparam int IDXW  = khani_idxw(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [IDXW-1:0]  in_idx,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             err
);

    localparam int CNTW = $clog2(N + 1);

    khani_state_t      r_state;
    logic [CNTW-1:0]   r_count;
    logic [IDXW-1:0]   r_rdPtr;
    logic              r_err;

    logic              w_accept;
    logic              w_idxBad;
    logic              w_we;
    logic              w_wocc;
    logic [CNTW-1:0]   w_countNext;
    logic              w_full;
    logic              w_outFire;
    logic              w_frameEnd;
    logic [WIDTH-1:0]  w_rdata;

    assign in_ready    = (r_state == ST_LOAD) && !rst;
    assign out_valid   = (r_state == ST_DRAIN);
    assign out_last    = (r_state == ST_DRAIN) && (r_rdPtr == IDXW'(N - 1));
    assign out_data    = (r_state == ST_DRAIN) ? w_rdata : '0;
    assign err         = r_err;

    assign w_accept    = in_valid && in_ready;
    assign w_idxBad    = int'(in_idx) >= N;
    assign w_we        = w_accept && !w_idxBad && !w_wocc;
    assign w_countNext = r_count + CNTW'(1);
    assign w_full      = (w_countNext == CNTW'(N));
    assign w_outFire   = out_valid && out_ready;
    assign w_frameEnd  = w_outFire && out_last;

    khani_scatter_buf #(
        .N     (N),
        .WIDTH (WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (w_frameEnd),
        .i_we    (w_we),
        .i_waddr (in_idx),
        .i_wdata (in_data),
        .i_raddr (r_rdPtr),
        .o_rdata (w_rdata),
        .o_wocc  (w_wocc)
    );

    // Load/drain FSM with accept counter, read pointer and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_count <= '0;
            r_rdPtr <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_accept) begin
                        r_count <= w_countNext;
                        if (w_idxBad || w_wocc) begin
                            r_err <= 1'b1;
                        end
                        if (in_last != w_full) begin
                            r_err <= 1'b1;
                        end
                        if (in_last || w_full) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_frameEnd) begin
                        r_state <= ST_LOAD;
                        r_rdPtr <= '0;
                        r_count <= '0;
                        r_err   <= 1'b0;
                    end else if (w_outFire) begin
                        r_rdPtr <= r_rdPtr + IDXW'(1);
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_khani_unsort.sv
// Directed self-checking bench for khani_unsort (N=6, WIDTH=8).
module tb_khani_unsort;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [2:0] in_idx;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       err;

    int checkCount = 0;
    int failCount  = 0;

    khani_unsort #(.N(6), .WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_idx    (in_idx),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Present one element and hold it until the edge that accepts it.
    task automatic applyStimulus(input int data, input int idx, input bit last);
        int waited;
        in_valid = 1'b1;
        in_data  = 8'(data);
        in_idx   = 3'(idx);
        in_last  = last;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            nextCycle();
            waited++;
        end
        check($sformatf("in_ready d=%0d", data), 32'(in_ready), 32'd1);
        nextCycle();
    endtask

    // Take one output element and compare it with the expected values.
    task automatic checkOutput(input int data, input bit last, input bit expErr, input string tag);
        int waited;
        out_ready = 1'b1;
        waited    = 0;
        while (!out_valid && waited < 20) begin
            nextCycle();
            waited++;
        end
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " data"},  32'(out_data),  32'(data));
        check({tag, " last"},  32'(out_last),  32'(last));
        check({tag, " err"},   32'(err),       32'(expErr));
        nextCycle();
    endtask

    task automatic feedFrame(input int d[6], input int ix[6], input int count, input int lastPos);
        for (int k = 0; k < count; k++) begin
            applyStimulus(d[k], ix[k], (k == lastPos));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkIdle(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready"},  32'(in_ready),  32'd1);
        check({tag, " err"},       32'(err),       32'd0);
    endtask

    int f1Data[6] = '{10, 20, 30, 40, 50, 60};
    int f1Idx [6] = '{2, 0, 5, 1, 4, 3};
    int f1Exp [6] = '{20, 40, 10, 60, 50, 30};
    int dpData[6] = '{1, 2, 3, 4, 5, 6};
    int dpIdx [6] = '{0, 1, 1, 2, 3, 4};
    int dpExp [6] = '{1, 2, 4, 5, 6, 0};
    int elData[6] = '{5, 6, 7, 8, 0, 0};
    int elIdx [6] = '{0, 1, 2, 3, 0, 0};
    int elExp [6] = '{5, 6, 7, 8, 0, 0};
    int rsData[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    int rsIdx [6] = '{5, 4, 3, 2, 1, 0};
    int rsExp [6] = '{8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    int seqIdx[6] = '{0, 1, 2, 3, 4, 5};
    int bData [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6};

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_idx    = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset values while rst is held high
        nextCycle();
        nextCycle();
        check("rst in_ready",  32'(in_ready),  32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_last",  32'(out_last),  32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        check("rst err",       32'(err),       32'd0);
        rst = 1'b0;
        nextCycle();
        checkIdle("post-reset");

        // Basic frame: one-cycle latency, original order restored
        for (int k = 0; k < 5; k++) begin
            applyStimulus(f1Data[k], f1Idx[k], 1'b0);
        end
        check("f1 pre-last out_valid", 32'(out_valid), 32'd0);
        applyStimulus(f1Data[5], f1Idx[5], 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("f1 latency out_valid", 32'(out_valid), 32'd1);
        for (int k = 0; k < 6; k++) begin
            checkOutput(f1Exp[k], (k == 5), 1'b0, $sformatf("f1 out%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("f1 end");

        // Same frame with out_ready pattern 1,0,0,1,0,0,...
        feedFrame(f1Data, f1Idx, 6, 5);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    check($sformatf("stall%0d.%0d valid", k, s), 32'(out_valid), 32'd1);
                    check($sformatf("stall%0d.%0d data", k, s),  32'(out_data),  32'(f1Exp[k]));
                    check($sformatf("stall%0d.%0d last", k, s),  32'(out_last),  32'(k == 5));
                    nextCycle();
                end
            end
            checkOutput(f1Exp[k], (k == 5), 1'b0, $sformatf("stall out%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("stall end");

        // Duplicate index: second write to slot 1 discarded, slot 5 empty
        feedFrame(dpData, dpIdx, 6, 5);
        for (int k = 0; k < 6; k++) begin
            checkOutput(dpExp[k], (k == 5), 1'b1, $sformatf("dup out%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("dup end");

        // Early in_last on the 4th element
        feedFrame(elData, elIdx, 4, 3);
        check("early drain next cycle", 32'(out_valid), 32'd1);
        check("early err", 32'(err), 32'd1);
        for (int k = 0; k < 6; k++) begin
            checkOutput(elExp[k], (k == 5), 1'b1, $sformatf("early out%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("early end");

        // Reset pulse after three accepts abandons the frame
        applyStimulus(8'hEE, 0, 1'b0);
        applyStimulus(8'hEE, 1, 1'b0);
        applyStimulus(8'hEE, 2, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst       = 1'b1;
        #1;
        check("midrst in_ready",  32'(in_ready),  32'd0);
        check("midrst out_valid", 32'(out_valid), 32'd0);
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("postrst%0d out_valid", c), 32'(out_valid), 32'd0);
            nextCycle();
        end
        out_ready = 1'b0;
        feedFrame(rsData, rsIdx, 6, 5);
        for (int k = 0; k < 6; k++) begin
            checkOutput(rsExp[k], (k == 5), 1'b0, $sformatf("rs out%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("rs end");

        // Back-to-back frames with in_valid and out_ready held high
        for (int k = 0; k < 6; k++) begin
            applyStimulus(f1Data[k], f1Idx[k], (k == 5));
        end
        in_data   = 8'(bData[0]);
        in_idx    = 3'(seqIdx[0]);
        in_last   = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("b2b A%0d valid", k), 32'(out_valid), 32'd1);
            check($sformatf("b2b A%0d data", k),  32'(out_data),  32'(f1Exp[k]));
            check($sformatf("b2b A%0d in_ready", k), 32'(in_ready), 32'd0);
            nextCycle();
        end
        check("b2b gap in_ready",  32'(in_ready),  32'd1);
        check("b2b gap out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(bData[k], seqIdx[k], (k == 5));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checkOutput(bData[k], (k == 5), 1'b0, $sformatf("b2b B%0d", k));
        end
        out_ready = 1'b0;
        checkIdle("b2b end");

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
